// File: rtl/alu_mac_ctrl_if.sv
// Bus bundle between the host/ALU/X-buffer/result-RAM side and the alu_mac_ctrl sequencer.
// cycle_cnt exists only when CTRL_PERF_CNT_EN is defined.
interface alu_mac_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int RES_W  = 18
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              buf_load;
    logic [1:0]        buf_row;
    logic [DATA_W-1:0] buf_data;
    logic              buf_rewind;
    logic              alu_en;
    logic [RES_W-1:0]  mu1;
    logic [RES_W-1:0]  mu2;
    logic [RES_W-1:0]  mu3;
    logic [RES_W-1:0]  mu4;
    logic              res_we;
    logic [3:0]        res_addr;
    logic [RES_W-1:0]  res_data;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0]       cycle_cnt;
`endif

    modport slave (
        input  start, abort, in_valid, in_data, mu1, mu2, mu3, mu4,
        output busy, done, in_ready, buf_load, buf_row, buf_data, buf_rewind,
               alu_en, res_we, res_addr, res_data
`ifdef CTRL_PERF_CNT_EN
        , output cycle_cnt
`endif
    );

    modport master (
        output start, abort, in_valid, in_data, mu1, mu2, mu3, mu4,
        input  busy, done, in_ready, buf_load, buf_row, buf_data, buf_rewind,
               alu_en, res_we, res_addr, res_data
`ifdef CTRL_PERF_CNT_EN
        , input cycle_cnt
`endif
    );
endinterface

// File: rtl/alu_mac_ctrl.sv
// Sequencer for the 4-lane MAC ALU: load 4 X rows, run 4 batches of 8 MAC cycles, serialise 16 results.
// Optional busy-cycle counter output cycle_cnt is enabled by defining CTRL_PERF_CNT_EN.
module alu_mac_ctrl (
    input logic           clk,
    input logic           rst,
    alu_mac_ctrl_if.slave bus
);
    localparam int ROWS    = 4;
    localparam int N_BATCH = 4;
    localparam int MAC_LEN = 8;
    localparam int RES_W   = 18;

    localparam logic [1:0] LAST_ROW   = 2'(ROWS - 1);
    localparam logic [1:0] LAST_BATCH = 2'(N_BATCH - 1);
    localparam logic [2:0] LAST_MAC   = 3'(MAC_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [1:0]       row_r;
    logic [1:0]       batch_r;
    logic [2:0]       mac_r;
    logic [1:0]       wr_lane_r;
    logic [1:0]       wr_left_r;
    logic [1:0]       wr_batch_r;
    logic [RES_W-1:0] shadow_r [ROWS];

    logic             busy_r;
    logic             done_r;
    logic             in_ready_r;
    logic             buf_load_r;
    logic [1:0]       buf_row_r;
    logic [63:0]      buf_data_r;
    logic             buf_rewind_r;
    logic             alu_en_r;
    logic             res_we_r;
    logic [3:0]       res_addr_r;
    logic [RES_W-1:0] res_data_r;

    logic start_acc_s;
    logic accept_s;
    logic abort_s;
    logic flush_done_s;

    assign start_acc_s  = (state_r == S_IDLE) && bus.start;
    assign accept_s     = (state_r == S_LOAD) && in_ready_r && bus.in_valid;
    assign abort_s      = (state_r != S_IDLE) && bus.abort;
    // The last write of the job is on the bus when the write-out has no lanes left.
    assign flush_done_s = (state_r == S_FLUSH) && res_we_r && (wr_left_r == 2'd0);

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (abort_s) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  next_state_s = bus.start ? S_LOAD : S_IDLE;
                S_LOAD:  next_state_s = (accept_s && (row_r == LAST_ROW)) ? S_RUN : S_LOAD;
                S_RUN:   next_state_s = (mac_r == LAST_MAC) ? S_DRAIN : S_RUN;
                S_DRAIN: next_state_s = (batch_r == LAST_BATCH) ? S_FLUSH : S_RUN;
                S_FLUSH: next_state_s = flush_done_s ? S_IDLE : S_FLUSH;
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // State register and row/MAC/batch counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            row_r   <= 2'd0;
            mac_r   <= 3'd0;
            batch_r <= 2'd0;
        end else begin
            state_r <= next_state_s;
            if (start_acc_s) begin
                row_r   <= 2'd0;
                mac_r   <= 3'd0;
                batch_r <= 2'd0;
            end else if (accept_s) begin
                row_r <= row_r + 2'd1;
            end else if (state_r == S_RUN) begin
                mac_r <= (mac_r == LAST_MAC) ? 3'd0 : mac_r + 3'd1;
            end else if (state_r == S_DRAIN) begin
                batch_r <= batch_r + 2'd1;
            end else begin
                row_r <= row_r;
            end
        end
    end

    // Control outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            alu_en_r     <= 1'b0;
            buf_rewind_r <= 1'b0;
            buf_load_r   <= 1'b0;
            buf_row_r    <= 2'd0;
            buf_data_r   <= 64'd0;
        end else begin
            busy_r       <= (next_state_s != S_IDLE) || (flush_done_s && !abort_s);
            done_r       <= flush_done_s && !abort_s;
            in_ready_r   <= (next_state_s == S_LOAD);
            alu_en_r     <= (next_state_s == S_RUN);
            buf_rewind_r <= (next_state_s == S_DRAIN);
            buf_load_r   <= accept_s && !abort_s;
            if (accept_s) begin
                buf_row_r  <= row_r;
                buf_data_r <= bus.in_data;
            end else begin
                buf_row_r  <= buf_row_r;
                buf_data_r <= buf_data_r;
            end
        end
    end

    // Shadow capture in DRAIN and the 4-write serial drain; lane 0 comes straight from mu1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                shadow_r[i] <= '0;
            end
            wr_lane_r  <= 2'd0;
            wr_left_r  <= 2'd0;
            wr_batch_r <= 2'd0;
            res_we_r   <= 1'b0;
            res_addr_r <= 4'd0;
            res_data_r <= '0;
        end else if (abort_s) begin
            wr_left_r <= 2'd0;
            res_we_r  <= 1'b0;
        end else if (state_r == S_DRAIN) begin
            shadow_r[0] <= bus.mu1;
            shadow_r[1] <= bus.mu2;
            shadow_r[2] <= bus.mu3;
            shadow_r[3] <= bus.mu4;
            wr_lane_r   <= 2'd1;
            wr_left_r   <= 2'd3;
            wr_batch_r  <= batch_r;
            res_we_r    <= 1'b1;
            res_addr_r  <= {batch_r, 2'd0};
            res_data_r  <= bus.mu1;
        end else if (wr_left_r != 2'd0) begin
            wr_lane_r  <= wr_lane_r + 2'd1;
            wr_left_r  <= wr_left_r - 2'd1;
            res_we_r   <= 1'b1;
            res_addr_r <= {wr_batch_r, wr_lane_r};
            res_data_r <= shadow_r[wr_lane_r];
        end else begin
            res_we_r <= 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] cycle_cnt_r;

    // Busy-cycle counter: cleared on start acceptance, saturating, held while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r <= 16'd0;
        end else if (start_acc_s) begin
            cycle_cnt_r <= 16'd0;
        end else if (busy_r && (cycle_cnt_r != 16'hFFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 16'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_r;
`endif

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.in_ready   = in_ready_r;
    assign bus.buf_load   = buf_load_r;
    assign bus.buf_row    = buf_row_r;
    assign bus.buf_data   = buf_data_r;
    assign bus.buf_rewind = buf_rewind_r;
    assign bus.alu_en     = alu_en_r;
    assign bus.res_we     = res_we_r;
    assign bus.res_addr   = res_addr_r;
    assign bus.res_data   = res_data_r;
endmodule
